// File: rtl/time_set_ctrl.sv
// Clock time-setting controller: edits a shadow copy of HH:MM digit by digit
// and loads it into the live digit registers with a one-cycle set strobe.
module time_set_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       mode_btn,
  input  logic       adv_btn,
  input  logic       up_btn,
  input  logic [3:0] cur_ht,
  input  logic [3:0] cur_hu,
  input  logic [3:0] cur_mt,
  input  logic [3:0] cur_mu,
  output logic [3:0] val_ht,
  output logic [3:0] val_hu,
  output logic [3:0] val_mt,
  output logic [3:0] val_mu,
  output logic       set,
  output logic       run_en,
  output logic [1:0] sel,
  output logic       editing,
  output logic       blink
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] E_HT   = 3'd1;
  localparam logic [2:0] E_HU   = 3'd2;
  localparam logic [2:0] E_MT   = 3'd3;
  localparam logic [2:0] E_MU   = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;

  localparam int CW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_S - 1);

  logic [2:0]    state_r, state_s;
  logic [3:0]    ht_r, hu_r, mt_r, mu_r;
  logic [3:0]    ht_s, hu_s, mt_s, mu_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          blink_r, blink_s;

  // Next-state, shadow-digit, idle-counter and blink computation
  always_comb begin
    state_s = state_r;
    ht_s    = ht_r;
    hu_s    = hu_r;
    mt_s    = mt_r;
    mu_s    = mu_r;
    cnt_s   = cnt_r;
    blink_s = blink_r;
    case (state_r)
      IDLE: begin
        cnt_s   = '0;
        blink_s = 1'b0;
        if (mode_btn) begin
          state_s = E_HT;
          ht_s    = cur_ht;
          hu_s    = cur_hu;
          mt_s    = cur_mt;
          mu_s    = cur_mu;
        end else begin
          state_s = IDLE;
        end
      end
      E_HT, E_HU, E_MT, E_MU: begin
        // Only the highest-priority button acts; any button resets the idle count
        if (mode_btn) begin
          state_s = COMMIT;
          cnt_s   = '0;
          blink_s = 1'b0;
        end else if (adv_btn) begin
          cnt_s   = '0;
          blink_s = 1'b0;
          case (state_r)
            E_HT:    state_s = E_HU;
            E_HU:    state_s = E_MT;
            E_MT:    state_s = E_MU;
            default: state_s = E_HT;
          endcase
        end else if (up_btn) begin
          cnt_s = '0;
          if (tick_1hz) begin
            blink_s = ~blink_r;
          end else begin
            blink_s = blink_r;
          end
          case (state_r)
            E_HT: begin
              if (ht_r >= 4'd2) begin
                ht_s = 4'd0;
              end else begin
                ht_s = ht_r + 4'd1;
              end
              // Entering the 20s clamps hour units to a legal 20..23
              if (ht_s == 4'd2 && hu_r > 4'd3) begin
                hu_s = 4'd3;
              end else begin
                hu_s = hu_r;
              end
            end
            E_HU: begin
              if ((ht_r == 4'd2 && hu_r >= 4'd3) || hu_r >= 4'd9) begin
                hu_s = 4'd0;
              end else begin
                hu_s = hu_r + 4'd1;
              end
            end
            E_MT: begin
              if (mt_r >= 4'd5) begin
                mt_s = 4'd0;
              end else begin
                mt_s = mt_r + 4'd1;
              end
            end
            default: begin
              if (mu_r >= 4'd9) begin
                mu_s = 4'd0;
              end else begin
                mu_s = mu_r + 4'd1;
              end
            end
          endcase
        end else if (tick_1hz) begin
          if (cnt_r == CNT_LAST) begin
            // Abandoned edit: drop the shadow copy, no load
            state_s = IDLE;
            cnt_s   = '0;
            blink_s = 1'b0;
            ht_s    = 4'd0;
            hu_s    = 4'd0;
            mt_s    = 4'd0;
            mu_s    = 4'd0;
          end else begin
            cnt_s   = cnt_r + CW'(1);
            blink_s = ~blink_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      COMMIT: begin
        state_s = IDLE;
        cnt_s   = '0;
        blink_s = 1'b0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        blink_s = 1'b0;
      end
    endcase
  end

  // State and shadow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ht_r    <= 4'd0;
      hu_r    <= 4'd0;
      mt_r    <= 4'd0;
      mu_r    <= 4'd0;
      cnt_r   <= '0;
      blink_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ht_r    <= ht_s;
      hu_r    <= hu_s;
      mt_r    <= mt_s;
      mu_r    <= mu_s;
      cnt_r   <= cnt_s;
      blink_r <= blink_s;
    end
  end

  // Output decode from registered state only
  always_comb begin
    set     = 1'b0;
    run_en  = 1'b0;
    editing = 1'b0;
    sel     = 2'd0;
    case (state_r)
      IDLE:    run_en = 1'b1;
      E_HT:    begin editing = 1'b1; sel = 2'd0; end
      E_HU:    begin editing = 1'b1; sel = 2'd1; end
      E_MT:    begin editing = 1'b1; sel = 2'd2; end
      E_MU:    begin editing = 1'b1; sel = 2'd3; end
      COMMIT:  set = 1'b1;
      default: run_en = 1'b0;
    endcase
  end

  assign val_ht = ht_r;
  assign val_hu = hu_r;
  assign val_mt = mt_r;
  assign val_mu = mu_r;
  assign blink  = blink_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: expected loads are queued by the
// stimulus and checked by a monitor whenever set is presented.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       mode_btn = 1'b0;
  logic       adv_btn = 1'b0;
  logic       up_btn = 1'b0;
  logic [3:0] cur_ht = 4'd0, cur_hu = 4'd0, cur_mt = 4'd0, cur_mu = 4'd0;
  logic [3:0] val_ht, val_hu, val_mt, val_mu;
  logic       set, run_en, editing, blink;
  logic [1:0] sel;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  time_set_ctrl #(.TIMEOUT_S(10)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .mode_btn(mode_btn), .adv_btn(adv_btn), .up_btn(up_btn),
    .cur_ht(cur_ht), .cur_hu(cur_hu), .cur_mt(cur_mt), .cur_mu(cur_mu),
    .val_ht(val_ht), .val_hu(val_hu), .val_mt(val_mt), .val_mu(val_mu),
    .set(set), .run_en(run_en), .sel(sel), .editing(editing), .blink(blink)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Monitor: every set pulse must match the oldest queued load
  always @(negedge clk) begin
    logic [15:0] e;
    if (set === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_set actual=%h required=none", {val_ht, val_hu, val_mt, val_mu});
      end else begin
        e = exp_q.pop_front();
        if ({val_ht, val_hu, val_mt, val_mu} !== e) begin
          failures++;
          $display("FAIL set_value actual=%h required=%h", {val_ht, val_hu, val_mt, val_mu}, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic m, input logic a, input logic u, input logic t);
    @(negedge clk);
    mode_btn = m; adv_btn = a; up_btn = u; tick_1hz = t;
    @(negedge clk);
    mode_btn = 1'b0; adv_btn = 1'b0; up_btn = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic set_cur(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    cur_ht = a; cur_hu = b; cur_mt = c; cur_mu = d;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_val"}, {16'd0, val_ht, val_hu, val_mt, val_mu}, 32'h0000);
    chk({tag, "_set"}, {31'd0, set}, 32'd0);
    chk({tag, "_run_en"}, {31'd0, run_en}, 32'd1);
    chk({tag, "_editing"}, {31'd0, editing}, 32'd0);
    chk({tag, "_sel"}, {30'd0, sel}, 32'd0);
    chk({tag, "_blink"}, {31'd0, blink}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");

    // Basic commit: HT 1->2->0 with no clamp (HU=2)
    set_cur(4'd1, 4'd2, 4'd3, 4'd4);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_editing", {31'd0, editing}, 32'd1);
    chk("t1_run_en_edit", {31'd0, run_en}, 32'd0);
    chk("t1_copy", {16'd0, val_ht, val_hu, val_mt, val_mu}, 32'h1234);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_up1", {28'd0, val_ht}, 32'd2);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_up2_wrap", {28'd0, val_ht}, 32'd0);
    exp_q.push_back(16'h0234);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_commit_set", {31'd0, set}, 32'd1);
    chk("t1_run_en_commit", {31'd0, run_en}, 32'd0);
    @(negedge clk);
    chk("t1_set_one_cycle", {31'd0, set}, 32'd0);
    chk("t1_run_en_idle", {31'd0, run_en}, 32'd1);

    // Clamp and wrap
    set_cur(4'd1, 4'd7, 4'd5, 4'd9);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_clamp", {24'd0, val_ht, val_hu}, 32'h23);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_sel_mt", {30'd0, sel}, 32'd2);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_mt_wrap", {28'd0, val_mt}, 32'd0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_mu_wrap", {28'd0, val_mu}, 32'd0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b0);
    set_cur(4'd2, 4'd3, 4'd0, 4'd1);
    exp_q.push_back(16'h2301);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_commit_set", {31'd0, set}, 32'd1);
    @(negedge clk);

    // Timeout after 10 idle ticks, no set
    set_cur(4'd1, 4'd2, 4'd3, 4'd4);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_still_edit_9", {31'd0, editing}, 32'd1);
    chk("t3_blink_odd", {31'd0, blink}, 32'd1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_timeout_idle", {31'd0, editing}, 32'd0);
    chk("t3_timeout_run_en", {31'd0, run_en}, 32'd1);
    chk("t3_timeout_blink", {31'd0, blink}, 32'd0);
    // Button on the 10th tick keeps the edit alive and restarts the count
    press(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_btn_wins", {31'd0, editing}, 32'd1);
    chk("t3_btn_wins_sel", {30'd0, sel}, 32'd0);
    chk("t3_btn_wins_ht", {28'd0, val_ht}, 32'd2);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_count_restarted", {31'd0, editing}, 32'd1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_second_timeout", {31'd0, run_en}, 32'd1);

    // Priority: all three buttons in E_MT commit unchanged shadows
    set_cur(4'd1, 4'd6, 4'd4, 4'd5);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_sel_mt", {30'd0, sel}, 32'd2);
    exp_q.push_back(16'h1645);
    press(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_prio_commit", {31'd0, set}, 32'd1);
    chk("t4_prio_mt", {28'd0, val_mt}, 32'd4);
    @(negedge clk);

    // Reset mid-edit
    set_cur(4'd1, 4'd2, 4'd3, 4'd4);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("t5");
    repeat (3) @(negedge clk);
    chk("t5_no_set", {31'd0, set}, 32'd0);

    // Reset on the edge that would enter COMMIT suppresses set
    press(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    mode_btn = 1'b1; reset = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0; reset = 1'b0;
    chk("t5c_set_suppressed", {31'd0, set}, 32'd0);
    chk("t5c_run_en", {31'd0, run_en}, 32'd1);

    // Advance wrap with blink restart
    set_cur(4'd0, 4'd9, 4'd5, 4'd8);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_blink_tick", {31'd0, blink}, 32'd1);
      press(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t6_sel", {30'd0, sel}, 32'((i + 1) % 4));
      chk("t6_blink_adv", {31'd0, blink}, 32'd0);
    end
    exp_q.push_back(16'h0958);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("pending_sets", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
